regfile_dump_unit: RTL and testbench
====================================

// Module: regfile_dump_unit
// PURPOSE
//  Reader at the far end of the register file read ports: on a start pulse (halt),
//  walks every register two at a time via rsel1/rsel2, buffers each pair and
//  streams (index, data) beats out over a valid/ready handshake to the
//  testbench/debug dump path. Never writes the register file; shares rsel muxing
//  with the datapath only while busy=1 (datapath gates the mux on busy).
// PARAMETERS
//  NREGS   32  registers to dump; even power of two, 2..32
//  WORD_W  32  data width; equals width of word_t
// PORTS
//  CLK           in   1       clock, all state on rising edge
//  RST           in   1       synchronous reset, active-high
//  start         in   1       begin dump; sampled in IDLE only
//  busy          out  1       1 from LOAD through DONE inclusive
//  done          out  1       1-cycle pulse in DONE
//  rsel1         out  5       regbits_t, read select port 1
//  rsel2         out  5       regbits_t, read select port 2
//  rdat1         in   WORD_W  combinational read data for rsel1
//  rdat2         in   WORD_W  combinational read data for rsel2
//  out_valid     out  1       beat valid
//  out_ready     in   1       sink accepts beat
//  out_idx       out  5       register index of beat
//  out_data      out  WORD_W  register value of beat
//  out_last      out  1       final beat of dump
//  out_cksum     out  1       beat carries checksum (0 when macro off)
// BEHAVIOUR
//  Reset: state=IDLE, pair=0, buf0=buf1=0, cksum=0; all outputs 0. RST mid-dump
//   aborts immediately to IDLE, no further beats, no done.
//  States IDLE, LOAD, EMIT0, EMIT1, [CKSUM], DONE.
//  IDLE: start=1 -> LOAD, pair=0; start ignored in every other state.
//  LOAD: rsel1={pair,0}, rsel2={pair,1}; buf0<=rdat1, buf1<=rdat2 -> EMIT0.
//  EMIT0: out_valid=1, idx={pair,0}, data=buf0; out_ready -> EMIT1.
//  EMIT1: out_valid=1, idx={pair,1}, data=buf1; out_ready: pair==NREGS/2-1 ->
//   CKSUM (macro on) or DONE with out_last=1 on this beat; else pair++ -> LOAD.
//  DONE: done=1, busy=1, out_valid=0 -> IDLE.
//  rsel1/rsel2 = {pair,0}/{pair,1} in every state (0/1 in IDLE).
//  Handshake: beat transfers on out_valid&&out_ready; idx/data/last/cksum held
//   stable while out_valid&&!out_ready; out_valid never drops before transfer.
//  Latency: start at cycle t -> LOAD t+1 -> first out_valid t+2. With out_ready
//   held 1: 3 cycles/pair, last beat at t+3*NREGS/2, done next cycle (+1 if CKSUM).
//  Register 0 dumped as read (rf returns 0); no special-casing.
// CONFIGURATION
//  REGDUMP_CHECKSUM_EN defined: cksum <= cksum ^ out_data on each transferred
//   data beat (cleared on start). After EMIT1 of last pair, CKSUM state emits one
//   beat: idx=0, data=cksum, out_cksum=1, out_last=1; on out_ready -> DONE. Data
//   beats then have out_last=0.
//  Undefined: no CKSUM state, no accumulator; out_cksum tied 0; last data beat
//   (idx NREGS-1) carries out_last=1.
// STRUCTURE
//  word_t, regbits_t from cpu_types_pkg; add regdump_state_t enum (IDLE, LOAD,
//  EMIT0, EMIT1, CKSUM, DONE) to cpu_types_pkg for bench visibility. Single module;
//  FSM + pair counter + 2-word buffer + optional XOR accumulator, no sub-module.
// TESTING
//  1 Regs loaded r[i]=0x1000_0000+i (r0=0), out_ready=1, start pulse -> 32 beats
//    idx 0..31 in order, data match, out_last on idx 31 (macro off), done 1 cycle.
//  2 out_ready toggled random 50% -> identical beat sequence, outputs stable while
//    stalled, no dropped/duplicated idx.
//  3 start held high for full dump and re-pulsed while busy -> exactly one dump;
//    new dump begins only after return to IDLE.
//  4 RST asserted during EMIT1 of pair 7 -> next cycle out_valid=0, busy=0, no done;
//    fresh start then dumps from idx 0.
//  5 REGDUMP_CHECKSUM_EN, r[i]=i -> 33rd beat out_cksum=1, data=0x0000_0000
//    (XOR 0..31), out_last=1; r[i]=1<<i -> data 0xFFFF_FFFE.
//  6 NREGS=8 -> 8 beats, pair wraps at 3, done at t+13 with out_ready=1 (macro off).

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-file word/select types and the state encoding
// of the register dump reader, kept here so benches can decode the state.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;
  localparam int REG_BITS  = 5;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [REG_BITS-1:0]  regbits_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EMIT0 = 3'd2,
    EMIT1 = 3'd3,
    CKSUM = 3'd4,
    DONE  = 3'd5
  } regdump_state_t;

endpackage

// File: rtl/regfile_dump_unit.sv
// Register file dump reader: on start, reads registers two at a time through
// rsel1/rsel2, buffers each pair and streams (index, data) beats over a
// valid/ready handshake. Never writes the register file.
// Optional feature: define REGDUMP_CHECKSUM_EN to append one XOR checksum beat
// after the last data beat (the checksum beat then carries out_last).
module regfile_dump_unit
  import cpu_types_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output regbits_t          rsel1,
  output regbits_t          rsel2,
  input  logic [WORD_W-1:0] rdat1,
  input  logic [WORD_W-1:0] rdat2,
  output logic              out_valid,
  input  logic              out_ready,
  output regbits_t          out_idx,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              out_cksum
);

  // Pair counter covers the upper index bits; the low bit selects the port.
  localparam int PAIR_W = REG_BITS - 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NREGS / 2 - 1);

  regdump_state_t    state_reg;
  logic [PAIR_W-1:0] pair_reg;
  logic [WORD_W-1:0] buf0_reg;
  logic [WORD_W-1:0] buf1_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              valid_reg;
  logic              last_pair;
`ifdef REGDUMP_CHECKSUM_EN
  logic [WORD_W-1:0] cksum_reg;
`endif

  assign last_pair = (pair_reg == LAST_PAIR);

  // Read selects follow the pair counter in every state; the datapath only
  // honours them while busy is high.
  assign rsel1     = {pair_reg, 1'b0};
  assign rsel2     = {pair_reg, 1'b1};
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign out_valid = valid_reg;

  // Dump sequencer: state, pair counter, pair buffer and control flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pair_reg  <= '0;
      buf0_reg  <= '0;
      buf1_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      cksum_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= LOAD;
            pair_reg  <= '0;
            busy_reg  <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            cksum_reg <= '0;
`endif
          end
        end
        LOAD: begin
          buf0_reg  <= rdat1;
          buf1_reg  <= rdat2;
          valid_reg <= 1'b1;
          state_reg <= EMIT0;
        end
        EMIT0: begin
          if (out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
            cksum_reg <= cksum_reg ^ buf0_reg;
`endif
            state_reg <= EMIT1;
          end
        end
        EMIT1: begin
          if (out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
            cksum_reg <= cksum_reg ^ buf1_reg;
`endif
            if (last_pair) begin
`ifdef REGDUMP_CHECKSUM_EN
              state_reg <= CKSUM;
`else
              state_reg <= DONE;
              valid_reg <= 1'b0;
              done_reg  <= 1'b1;
`endif
            end else begin
              pair_reg  <= pair_reg + 1'b1;
              valid_reg <= 1'b0;
              state_reg <= LOAD;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CKSUM: begin
          if (out_ready) begin
            valid_reg <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
`endif
        DONE: begin
          busy_reg  <= 1'b0;
          pair_reg  <= '0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Beat payload decoded from the registered state and buffers, so it is
  // inherently stable while a beat is stalled.
  always_comb begin
    out_idx   = '0;
    out_data  = '0;
    out_last  = 1'b0;
    out_cksum = 1'b0;
    case (state_reg)
      EMIT0: begin
        out_idx  = rsel1;
        out_data = buf0_reg;
      end
      EMIT1: begin
        out_idx  = rsel2;
        out_data = buf1_reg;
`ifndef REGDUMP_CHECKSUM_EN
        out_last = last_pair;
`endif
      end
`ifdef REGDUMP_CHECKSUM_EN
      CKSUM: begin
        out_data  = cksum_reg;
        out_cksum = 1'b1;
        out_last  = 1'b1;
      end
`endif
      default: begin
        out_idx = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Self-checking bench for regfile_dump_unit: a behavioural register file feeds
// the read ports and a beat list built from the register contents is compared
// against the streamed output under random back-pressure, start jitter and a
// mid-dump reset. Define REGDUMP_CHECKSUM_EN to exercise the checksum beat.
module tb_regfile_dump_unit;
  import cpu_types_pkg::*;

  localparam int NREGS  = 32;
  localparam int WORD_W = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic              busy, done, out_valid, out_last, out_cksum;
  regbits_t          rsel1, rsel2, out_idx;
  logic [WORD_W-1:0] rdat1, rdat2, out_data;
  logic [WORD_W-1:0] regs [0:31];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]        idx;
    logic [WORD_W-1:0] data;
    logic              last;
    logic              ck;
  } beat_t;
  beat_t expq[$];

  assign rdat1 = regs[rsel1];
  assign rdat2 = regs[rsel2];

  always #5 clk = ~clk;

  regfile_dump_unit #(.NREGS(NREGS), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .out_last(out_last), .out_cksum(out_cksum)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected beat list: every register in index order, then the XOR beat.
  task automatic build_expected();
    logic [WORD_W-1:0] x;
    beat_t b;
    expq.delete();
    x = '0;
    for (int i = 0; i < NREGS; i++) begin
      b.idx  = 5'(i);
      b.data = regs[i];
      b.last = (i == NREGS - 1) && (CK == 0);
      b.ck   = 1'b0;
      expq.push_back(b);
      x = x ^ regs[i];
    end
    if (CK != 0) begin
      b.idx  = 5'd0;
      b.data = x;
      b.last = 1'b1;
      b.ck   = 1'b1;
      expq.push_back(b);
    end
  endtask

  // One dump from the current negedge. abort_idx>=0 resets the DUT while that
  // beat is presented.
  task automatic run_dump(input int ready_pct, input bit jitter_start,
                          input int abort_idx, input bit check_timing);
    int  k, first_k, done_k, done_cnt;
    bit  prev_stall, finished;
    beat_t h;
    build_expected();
    start = 1'b1;
    k = 0; first_k = -1; done_k = -1; done_cnt = 0;
    prev_stall = 1'b0; finished = 1'b0;
    while (!finished && k < 3000) begin
      @(negedge clk);
      k++;
      start     = jitter_start ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      check("busy_during_dump", busy, 1'b1);
      if (prev_stall) check("valid_held", out_valid, 1'b1);
      if (done) begin
        done_cnt++;
        done_k = k;
        check("valid_in_done", out_valid, 1'b0);
        start = 1'b0;
        finished = 1'b1;
      end else if (out_valid) begin
        if (first_k < 0) first_k = k;
        if (expq.size() == 0) begin
          check("extra_beat", 1'b1, 1'b0);
        end else begin
          h = expq[0];
          check("idx", out_idx, h.idx);
          check("data", out_data, h.data);
          check("last", out_last, h.last);
          check("cksum_flag", out_cksum, h.ck);
          if (out_ready) begin
            $display("beat idx=%0d data=%08h last=%0b ck=%0b", out_idx, out_data, out_last, out_cksum);
            void'(expq.pop_front());
          end
        end
        if (abort_idx >= 0 && int'(out_idx) == abort_idx) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check("abort_valid", out_valid, 1'b0);
          check("abort_busy", busy, 1'b0);
          check("abort_done", done, 1'b0);
          for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("abort_quiet", {done, out_valid, busy}, 3'b000);
          end
          return;
        end
      end
      prev_stall = out_valid && !out_ready;
    end
    if (!finished) check("timeout", 1'b0, 1'b1);
    check("done_pulses", done_cnt, 1);
    check("beats_missing", expq.size(), 0);
    if (check_timing) begin
      check("first_valid_cycle", first_k, 2);
      check("done_cycle", done_k, 3 * NREGS / 2 + 1 + CK);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("idle_after_dump", {done, out_valid, busy}, 3'b000);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_idx", out_idx, 5'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last", out_last, 1'b0);
    check("rst_cksum", out_cksum, 1'b0);
    check("rst_rsel1", rsel1, 5'd0);
    check("rst_rsel2", rsel2, 5'd1);
    rst = 1'b0;
    @(negedge clk);

    // Incrementing pattern, sink always ready, latency checked.
    for (int i = 0; i < NREGS; i++) regs[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
    run_dump(100, 1'b0, -1, 1'b1);

    // Random contents under 50% back-pressure.
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    run_dump(50, 1'b0, -1, 1'b0);

    // Start jittering throughout the dump must not restart it.
    run_dump(70, 1'b1, -1, 1'b0);

    // Reset during EMIT1 of pair 7, then a clean dump from index 0.
    run_dump(100, 1'b0, 15, 1'b0);
    run_dump(100, 1'b0, -1, 1'b1);

    // Checksum-friendly patterns (XOR of 0..31 is 0; of 1<<i is all ones).
    for (int i = 0; i < NREGS; i++) regs[i] = 32'(i);
    run_dump(100, 1'b0, -1, 1'b1);
    for (int i = 0; i < NREGS; i++) regs[i] = 32'd1 << i;
    run_dump(60, 1'b0, -1, 1'b0);

    // A few more random dumps at random back-pressure.
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
      run_dump($urandom_range(20, 100), 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
